demux_reg16: RTL and testbench



---
 rtl/demux_reg16.sv | 112 +++++++++++
 tb/tb_demux_reg16.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_reg16.sv
// demux_reg16: 16-entry word bank with a valid/ready write port and a sequenced 16-cycle clear sweep.
// Optional per-entry dirty flags are built when DEMUX_REG16_DIRTY_EN is defined.
module demux_reg16 #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [3:0]       wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr_req,
   output logic             busy,
`ifdef DEMUX_REG16_DIRTY_EN
   output logic [15:0]      dirty,
`endif
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [WIDTH-1:0] out8,
   output logic [WIDTH-1:0] out9,
   output logic [WIDTH-1:0] out10,
   output logic [WIDTH-1:0] out11,
   output logic [WIDTH-1:0] out12,
   output logic [WIDTH-1:0] out13,
   output logic [WIDTH-1:0] out14,
   output logic [WIDTH-1:0] out15
);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic [3:0]       cnt_d;
   logic [WIDTH-1:0] bank_q [16];
   logic [15:0]      dirty_q;

   assign cnt_d = cnt_q + 4'd1;

   // Writes are only taken in IDLE; a write coinciding with clr_req still lands and is swept later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dirty_q <= '0;
         for (int i = 0; i < 16; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (wr_valid) begin
                  bank_q[wr_sel]  <= wr_data;
                  dirty_q[wr_sel] <= 1'b1;
               end
               if (clr_req) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
               end
            end
            CLEAR: begin
               bank_q[cnt_q]  <= CLR_VALUE;
               dirty_q[cnt_q] <= 1'b0;
               if (cnt_q == 4'd15) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign wr_ready = (state_q == IDLE);
   assign busy     = (state_q == CLEAR);

`ifdef DEMUX_REG16_DIRTY_EN
   assign dirty = dirty_q;
`else
   logic unusedDirty;
   assign unusedDirty = ^dirty_q;
`endif

   assign out0  = bank_q[0];
   assign out1  = bank_q[1];
   assign out2  = bank_q[2];
   assign out3  = bank_q[3];
   assign out4  = bank_q[4];
   assign out5  = bank_q[5];
   assign out6  = bank_q[6];
   assign out7  = bank_q[7];
   assign out8  = bank_q[8];
   assign out9  = bank_q[9];
   assign out10 = bank_q[10];
   assign out11 = bank_q[11];
   assign out12 = bank_q[12];
   assign out13 = bank_q[13];
   assign out14 = bank_q[14];
   assign out15 = bank_q[15];

endmodule

// File: tb/tb_demux_reg16.sv
// Scoreboarded bench for demux_reg16: stimulus pushes expected post-edge snapshots, a monitor pops and compares.
module tb_demux_reg16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wrValid = 1'b0;
   logic        wrReady;
   logic [3:0]  wrSel = '0;
   logic [31:0] wrData = '0;
   logic        clrReq = 1'b0;
   logic        busy;
   logic [31:0] outW [16];
`ifdef DEMUX_REG16_DIRTY_EN
   logic [15:0] dirty;
`endif

   typedef struct packed {
      logic [15:0][31:0] outs;
      logic [15:0]       dirty;
      logic              busy;
      logic              ready;
   } expT;

   expT expQ[$];

   int checkCount = 0;
   int failCount  = 0;
   int busyCnt;
   int waitCnt;

   logic [15:0][31:0] mBank;
   logic [15:0]       mDirty;
   logic              mClear;
   logic [3:0]        mCnt;

   always #5 clk = ~clk;

   demux_reg16 dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wrValid),
      .wr_ready (wrReady),
      .wr_sel   (wrSel),
      .wr_data  (wrData),
      .clr_req  (clrReq),
      .busy     (busy),
`ifdef DEMUX_REG16_DIRTY_EN
      .dirty    (dirty),
`endif
      .out0     (outW[0]),
      .out1     (outW[1]),
      .out2     (outW[2]),
      .out3     (outW[3]),
      .out4     (outW[4]),
      .out5     (outW[5]),
      .out6     (outW[6]),
      .out7     (outW[7]),
      .out8     (outW[8]),
      .out9     (outW[9]),
      .out10    (outW[10]),
      .out11    (outW[11]),
      .out12    (outW[12]),
      .out13    (outW[13]),
      .out14    (outW[14]),
      .out15    (outW[15])
   );

   // Drive one cycle of inputs on the falling edge and queue what the bank must look like after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [3:0] sel, input logic [31:0] data,
                                input logic clr, input logic rst);
      expT e;
      @(negedge clk);
      wrValid = v;
      wrSel   = sel;
      wrData  = data;
      clrReq  = clr;
      reset   = rst;
      if (rst) begin
         mBank  = '0;
         mDirty = '0;
         mClear = 1'b0;
         mCnt   = '0;
      end else if (!mClear) begin
         if (v) begin
            mBank[sel]  = data;
            mDirty[sel] = 1'b1;
         end
         if (clr) begin
            mClear = 1'b1;
            mCnt   = '0;
         end
      end else begin
         mBank[mCnt]  = 32'h0;
         mDirty[mCnt] = 1'b0;
         if (mCnt == 4'd15) begin
            mClear = 1'b0;
            mCnt   = '0;
         end else begin
            mCnt = mCnt + 4'd1;
         end
      end
      e.outs  = mBank;
      e.dirty = mDirty;
      e.busy  = mClear;
      e.ready = !mClear;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: after every rising edge, compare the DUT against the oldest queued expectation.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            for (int i = 0; i < 16; i++) begin
               checkCount++;
               if (outW[i] !== e.outs[i]) begin
                  failCount++;
                  $display("[TB] FAIL sb_out%0d got=%h expected=%h at %0t", i, outW[i], e.outs[i], $time);
               end
            end
            checkCount++;
            if (busy !== e.busy) begin
               failCount++;
               $display("[TB] FAIL sb_busy got=%b expected=%b at %0t", busy, e.busy, $time);
            end
            checkCount++;
            if (wrReady !== e.ready) begin
               failCount++;
               $display("[TB] FAIL sb_ready got=%b expected=%b at %0t", wrReady, e.ready, $time);
            end
`ifdef DEMUX_REG16_DIRTY_EN
            checkCount++;
            if (dirty !== e.dirty) begin
               failCount++;
               $display("[TB] FAIL sb_dirty got=%h expected=%h at %0t", dirty, e.dirty, $time);
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      mBank  = '0;
      mDirty = '0;
      mClear = 1'b0;
      mCnt   = '0;

      // Reset for two cycles, then a single write to entry 5.
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
      settle();
      checkOutput("resetReady", {31'b0, wrReady}, 32'd1);
      checkOutput("resetBusy", {31'b0, busy}, 32'd0);
      checkOutput("resetOut0", outW[0], 32'h0);
      applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0);
      settle();
      checkOutput("writeOut5", outW[5], 32'hDEADBEEF);
      checkOutput("writeOut4", outW[4], 32'h0);

      // Back-to-back fill of all 16 entries with no stalls.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 4'(i), 32'h1000_0000 + i, 1'b0, 1'b0);
         settle();
         checkOutput("fillOut", outW[i], 32'h1000_0000 + i);
         checkOutput("fillReady", {31'b0, wrReady}, 32'd1);
      end

      // Clear sweep while a write to entry 3 is held pending.
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
      busyCnt = 0;
      for (waitCnt = 0; waitCnt < 40; waitCnt++) begin
         settle();
         if (!busy) break;
         busyCnt++;
         checkOutput("sweepReadyLow", {31'b0, wrReady}, 32'd0);
         applyStimulus(1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 1'b0);
      end
      checkOutput("sweepBusyCycles", busyCnt, 32'd16);
      checkOutput("blockedOut3", outW[3], 32'h0);
      checkOutput("afterSweepReady", {31'b0, wrReady}, 32'd1);
      applyStimulus(1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 1'b0);
      settle();
      checkOutput("acceptedOut3", outW[3], 32'hA5A5A5A5);

      // Refill, then write entry 15 on the same edge as clr_req.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 4'(i), 32'h2000_0000 + i, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 4'd15, 32'h0000_1234, 1'b1, 1'b0);
      settle();
      checkOutput("simulOut15", outW[15], 32'h0000_1234);
`ifdef DEMUX_REG16_DIRTY_EN
      checkOutput("simulDirtySet", {31'b0, dirty[15]}, 32'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
         settle();
         if (i == 14) checkOutput("simulOut15Held", outW[15], 32'h0000_1234);
      end
      checkOutput("simulOut15Cleared", outW[15], 32'h0);
      checkOutput("simulBusyDone", {31'b0, busy}, 32'd0);
`ifdef DEMUX_REG16_DIRTY_EN
      checkOutput("simulDirtyClr", {31'b0, dirty[15]}, 32'd0);
`endif

      // Reset landing on sweep cycle 7, then a complete fresh sweep.
      for (int i = 8; i < 14; i++) begin
         applyStimulus(1'b1, 4'(i), 32'h3000_0000 + i, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
      end
      settle();
      checkOutput("preResetOut11", outW[11], 32'h3000_000B);
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
      settle();
      checkOutput("midResetBusy", {31'b0, busy}, 32'd0);
      checkOutput("midResetReady", {31'b0, wrReady}, 32'd1);
      checkOutput("midResetOut11", outW[11], 32'h0);
      applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
      busyCnt = 0;
      for (waitCnt = 0; waitCnt < 40; waitCnt++) begin
         settle();
         if (!busy) break;
         busyCnt++;
         applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
      end
      checkOutput("resweepBusyCycles", busyCnt, 32'd16);

      applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
      settle();
      #2;
      checkOutput("scoreboardDrained", expQ.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
